// File: rtl/shifter_pkg.sv
// shifter_pkg: shared width, op-code type and op-code values for the shifter unit
package shifter_pkg;
    localparam int WIDTH_C = 32;
    typedef logic [2:0] sh_op_t;
    localparam sh_op_t OP_PASS = 3'b000;
    localparam sh_op_t OP_SLL  = 3'b001;
    localparam sh_op_t OP_SRL  = 3'b010;
    localparam sh_op_t OP_SRA  = 3'b011;
    localparam sh_op_t OP_ROL  = 3'b100;
    localparam sh_op_t OP_ROR  = 3'b101;
    localparam sh_op_t OP_SWAP = 3'b110;
endpackage

// File: rtl/shifter_comb.sv
// shifter_comb: combinational single-step shift/rotate/swap datapath
// Ports: in (operand), sh (op code) -> result, carry (shifted-out bit, 0 for PASS/SWAP/reserved)
module shifter_comb
    import shifter_pkg::*;
(
    input  logic [WIDTH_C-1:0] in,
    input  sh_op_t             sh,
    output logic [WIDTH_C-1:0] result,
    output logic               carry
);
    always_comb begin
        result = in;
        carry  = 1'b0;
        case (sh)
            OP_SLL:  {carry, result} = {in, 1'b0};
            OP_SRL:  {result, carry} = {1'b0, in};
            OP_SRA:  {result, carry} = {in[31], in};
            OP_ROL:  {carry, result} = {in[31], in[30:0], in[31]};
            OP_ROR:  {result, carry} = {in[0], in};
            OP_SWAP: result = {in[15:0], in[31:16]};
            default: ;
        endcase
    end
endmodule

// File: rtl/shifter_unit.sv
// shifter_unit: registered 32-bit single-step shifter/rotator, one-cycle latency
// Ports: clk, rst (async active-high), in_valid/in/sh (operand + op) ->
//        out, out_valid, zero (result == 0), carry (only when SHIFTER_CARRY_EN is defined)
module shifter_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sh,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero
`ifdef SHIFTER_CARRY_EN
    ,
    output logic             carry
`endif
);
    logic [WIDTH-1:0] res, out_d, out_q;
    logic             valid_d, valid_q, zero_d, zero_q, res_carry;

    shifter_comb u_comb (
        .in     (in),
        .sh     (sh),
        .result (res),
        .carry  (res_carry)
    );

    // Data registers hold while idle; only out_valid follows in_valid every cycle.
    always_comb begin
        out_d   = in_valid ? res : out_q;
        zero_d  = in_valid ? (res == '0) : zero_q;
        valid_d = in_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign zero      = zero_q;

`ifdef SHIFTER_CARRY_EN
    logic carry_d, carry_q;
    always_comb carry_d = in_valid ? res_carry : carry_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) carry_q <= 1'b0;
        else     carry_q <= carry_d;
    end
    assign carry = carry_q;
`else
    logic carry_unused;
    assign carry_unused = res_carry;
`endif
endmodule

// File: tb/tb_shifter_unit.sv
// tb_shifter_unit: directed literal checks plus randomized stream against a behavioural model
module tb_shifter_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vin = 1'b0;
    logic [31:0] din = '0;
    logic [2:0]  sh = '0;
    logic [31:0] out;
    logic        out_valid, zero, carry;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] m_out = '0;
    logic        m_valid = 1'b0, m_zero = 1'b1, m_carry = 1'b0;

    shifter_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vin),
        .in        (din),
        .sh        (sh),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero)
`ifdef SHIFTER_CARRY_EN
        ,
        .carry     (carry)
`endif
    );
`ifndef SHIFTER_CARRY_EN
    assign carry = m_carry;
`endif

    always #5 clk = ~clk;

    // Reference: {carry, result} from the op table using plain integer arithmetic.
    function automatic logic [32:0] ref_op(logic [31:0] a, logic [2:0] s);
        longint unsigned x = 64'(a);
        longint unsigned top = 64'd2147483648;
        longint unsigned m = 64'd4294967296;
        logic c_hi = (x >= top);
        logic c_lo = (x % 2) == 1;
        case (s)
            3'd1: return {c_hi, 32'((x * 2) % m)};
            3'd2: return {c_lo, 32'(x / 2)};
            3'd3: return {c_lo, 32'(x / 2 + (c_hi ? top : 64'd0))};
            3'd4: return {c_hi, 32'((x * 2) % m + x / top)};
            3'd5: return {c_lo, 32'(x / 2 + (x % 2) * top)};
            3'd6: return {1'b0, 32'((x % 65536) * 65536 + x / 65536)};
            default: return {1'b0, a};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [32:0] r;
        if (rst) begin
            m_out = '0; m_valid = 1'b0; m_zero = 1'b1; m_carry = 1'b0;
        end else begin
            r = ref_op(din, sh);
            m_valid = vin;
            if (vin) begin
                m_out = r[31:0]; m_zero = (r[31:0] == 0); m_carry = r[32];
            end
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (out !== m_out || out_valid !== m_valid || zero !== m_zero || carry !== m_carry) begin
            n_fail++;
            $display("FAIL model t=%0t out=%h/%h valid=%b/%b zero=%b/%b carry=%b/%b (got/exp)",
                     $time, out, m_out, out_valid, m_valid, zero, m_zero, carry, m_carry);
        end
    end

    task automatic lit(string name, logic [31:0] e_out, logic e_valid, logic e_zero, logic e_carry);
        n_checks++;
        if (out !== e_out || out_valid !== e_valid || zero !== e_zero
`ifdef SHIFTER_CARRY_EN
            || carry !== e_carry
`endif
        ) begin
            n_fail++;
            $display("FAIL %s out=%h exp=%h valid=%b exp=%b zero=%b exp=%b carry=%b exp=%b",
                     name, out, e_out, out_valid, e_valid, zero, e_zero, carry, e_carry);
        end
    endtask

    task automatic apply(logic [31:0] a, logic [2:0] s, logic v);
        din = a; sh = s; vin = v;
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [31:0] a; logic [2:0] s; logic [31:0] e; logic c; } vec_t;
    vec_t vecs[$] = '{
        '{32'h0000000F, 3'd0, 32'h0000000F, 1'b0},
        '{32'h0000000F, 3'd1, 32'h0000001E, 1'b0},
        '{32'h0000000F, 3'd2, 32'h00000007, 1'b1},
        '{32'h0000000F, 3'd3, 32'h00000007, 1'b1},
        '{32'h0000000F, 3'd5, 32'h80000007, 1'b1},
        '{32'hF0000000, 3'd0, 32'hF0000000, 1'b0},
        '{32'hF0000000, 3'd1, 32'hE0000000, 1'b1},
        '{32'hF0000000, 3'd2, 32'h78000000, 1'b0},
        '{32'hF0000000, 3'd3, 32'hF8000000, 1'b0},
        '{32'hF0000000, 3'd5, 32'h78000000, 1'b0},
        '{32'h80000000, 3'd4, 32'h00000001, 1'b1},
        '{32'h80000000, 3'd1, 32'h00000000, 1'b1},
        '{32'h1234ABCD, 3'd6, 32'hABCD1234, 1'b0},
        '{32'h1234ABCD, 3'd7, 32'h1234ABCD, 1'b0}
    };

    initial begin
        #2 rst = 1'b1;
        #1 lit("reset_async", 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].s, 1'b1);
            lit($sformatf("op%0d_%h", vecs[i].s, vecs[i].a), vecs[i].e, 1'b1, vecs[i].e == 0, vecs[i].c);
        end
        apply(32'hDEADBEEF, 3'd1, 1'b0);
        lit("hold", 32'h1234ABCD, 1'b0, 1'b0, 1'b0);
        apply(32'hDEADBEEF, 3'd6, 1'b0);
        lit("hold_sh_change", 32'h1234ABCD, 1'b0, 1'b0, 1'b0);
        apply(32'h00000003, 3'd1, 1'b1);
        lit("pre_reset_op", 32'h00000006, 1'b1, 1'b0, 1'b0);
        din = 32'h0000000F; sh = 3'd5; vin = 1'b1;
        #1 rst = 1'b1;
        #1 lit("mid_reset", 32'h0, 1'b0, 1'b1, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        lit("post_reset_op", 32'h80000007, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h80000000;
                2: a = 32'h00000001;
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            apply(a, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
        end
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
